// File: rtl/alarm_tone_gen.sv
// Alarm cadence generator: groups of square-wave tone bursts separated by gaps,
// then a long pause, with PWM loudness control and amplifier enable.
module alarm_tone_gen #(
  parameter int unsigned TONE_HALF_CYC   = 25000,
  parameter int unsigned BEEP_ON_CYC     = 25000000,
  parameter int unsigned BEEP_OFF_CYC    = 25000000,
  parameter int unsigned PAUSE_CYC       = 50000000,
  parameter int unsigned BEEPS_PER_GROUP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm,
  input  logic [7:0] volume,
  output logic       AUD_PWM,
  output logic       AUD_SD,
  output logic       beeping,
  output logic [7:0] beat_idx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEEP  = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam logic [31:0] TONE_LAST  = 32'(TONE_HALF_CYC - 1);
  localparam logic [31:0] BEEP_LAST  = 32'(BEEP_ON_CYC - 1);
  localparam logic [31:0] GAP_LAST   = 32'(BEEP_OFF_CYC - 1);
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYC - 1);
  localparam logic [8:0]  GROUP_LEN  = 9'(BEEPS_PER_GROUP);

  logic [1:0]  state_r;
  logic [31:0] phase_cnt_r;
  logic [31:0] tone_cnt_r;
  logic        tone_hi_r;
  logic [7:0]  pwm_cnt_r;
  logic [7:0]  beat_idx_r;

  logic [1:0]  state_nxt_s;
  logic [31:0] phase_nxt_s;
  logic [31:0] tone_cnt_nxt_s;
  logic        tone_hi_nxt_s;
  logic [7:0]  beat_nxt_s;
  logic        more_beats_s;

  // Widened so a single-burst group never compares against zero.
  assign more_beats_s = ({1'b0, beat_idx_r} + 9'd1) < GROUP_LEN;
  assign beat_idx     = beat_idx_r;

  // Next-state and counter update; alarm drop outranks every other transition.
  always_comb begin
    state_nxt_s    = state_r;
    phase_nxt_s    = phase_cnt_r + 32'd1;
    tone_cnt_nxt_s = tone_cnt_r;
    tone_hi_nxt_s  = tone_hi_r;
    beat_nxt_s     = beat_idx_r;
    if (!alarm) begin
      state_nxt_s    = ST_IDLE;
      phase_nxt_s    = 32'd0;
      tone_cnt_nxt_s = 32'd0;
      tone_hi_nxt_s  = 1'b0;
      beat_nxt_s     = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s    = ST_BEEP;
          phase_nxt_s    = 32'd0;
          tone_cnt_nxt_s = 32'd0;
          tone_hi_nxt_s  = 1'b1;
          beat_nxt_s     = 8'd0;
        end
        ST_BEEP: begin
          if (tone_cnt_r == TONE_LAST) begin
            tone_cnt_nxt_s = 32'd0;
            tone_hi_nxt_s  = ~tone_hi_r;
          end else begin
            tone_cnt_nxt_s = tone_cnt_r + 32'd1;
          end
          if (phase_cnt_r == BEEP_LAST) begin
            phase_nxt_s = 32'd0;
            if (more_beats_s) begin
              state_nxt_s = ST_GAP;
              beat_nxt_s  = beat_idx_r + 8'd1;
            end else begin
              state_nxt_s = ST_PAUSE;
              beat_nxt_s  = 8'd0;
            end
          end else begin
            state_nxt_s = ST_BEEP;
          end
        end
        ST_GAP, ST_PAUSE: begin
          if (((state_r == ST_GAP) && (phase_cnt_r == GAP_LAST)) ||
              ((state_r == ST_PAUSE) && (phase_cnt_r == PAUSE_LAST))) begin
            state_nxt_s    = ST_BEEP;
            phase_nxt_s    = 32'd0;
            tone_cnt_nxt_s = 32'd0;
            tone_hi_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          phase_nxt_s    = 32'd0;
          tone_cnt_nxt_s = 32'd0;
          tone_hi_nxt_s  = 1'b0;
          beat_nxt_s     = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= 32'd0;
      tone_cnt_r  <= 32'd0;
      tone_hi_r   <= 1'b0;
      pwm_cnt_r   <= 8'd0;
      beat_idx_r  <= 8'd0;
      AUD_PWM     <= 1'b0;
      AUD_SD      <= 1'b0;
      beeping     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      phase_cnt_r <= phase_nxt_s;
      tone_cnt_r  <= tone_cnt_nxt_s;
      tone_hi_r   <= tone_hi_nxt_s;
      pwm_cnt_r   <= pwm_cnt_r + 8'd1;
      beat_idx_r  <= beat_nxt_s;
      AUD_SD      <= (state_nxt_s != ST_IDLE);
      beeping     <= (state_nxt_s == ST_BEEP);
      // The edge that leaves BEEP always silences the pin.
      AUD_PWM     <= (state_r == ST_BEEP) && (state_nxt_s == ST_BEEP) &&
                     tone_hi_r && (pwm_cnt_r < volume);
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Randomised and directed bench for alarm_tone_gen against a timeline model
// of the burst/gap/pause cadence, for groups of three bursts and of one burst.
module tb_alarm_tone_gen;
  localparam int H   = 2;
  localparam int ON  = 8;
  localparam int OFF = 4;
  localparam int PS  = 10;

  logic       clk;
  logic       reset;
  logic       alarm;
  logic [7:0] volume;
  logic       pwm3, sd3, bp3, pwm1, sd1, bp1;
  logic [7:0] idx3, idx1;

  alarm_tone_gen #(.TONE_HALF_CYC(H), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF),
                   .PAUSE_CYC(PS), .BEEPS_PER_GROUP(3)) u_dut3 (
    .clk(clk), .reset(reset), .alarm(alarm), .volume(volume),
    .AUD_PWM(pwm3), .AUD_SD(sd3), .beeping(bp3), .beat_idx(idx3));

  alarm_tone_gen #(.TONE_HALF_CYC(H), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF),
                   .PAUSE_CYC(PS), .BEEPS_PER_GROUP(1)) u_dut1 (
    .clk(clk), .reset(reset), .alarm(alarm), .volume(volume),
    .AUD_PWM(pwm1), .AUD_SD(sd1), .beeping(bp1), .beat_idx(idx1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: per instance, whether a pattern runs and cycles since it started
  int m_n[2] = '{3, 1};
  bit m_active[2];
  int m_t[2];
  int m_pwm;
  bit e_pwm[2], e_sd[2], e_beep[2];
  int e_idx[2];

  function automatic void seg(input int t, input int n, output bit inb,
                              output int off, output int idx);
    int per, p, st;
    per = n * ON + (n - 1) * OFF + PS;
    p   = t % per;
    inb = 1'b0; off = 0; idx = 0;
    for (int k = 0; k < n; k++) begin
      st = k * (ON + OFF);
      if (p >= st && p < st + ON) begin
        inb = 1'b1; off = p - st; idx = k; return;
      end
      if (k < n - 1 && p >= st + ON && p < st + ON + OFF) begin
        idx = k + 1; return;
      end
    end
  endfunction

  task automatic model_step();
    bit pre_inb, pre_th, nx_inb;
    int off, idx;
    for (int i = 0; i < 2; i++) begin
      pre_inb = 1'b0; pre_th = 1'b0;
      if (m_active[i]) begin
        seg(m_t[i], m_n[i], pre_inb, off, idx);
        pre_th = ((off / H) % 2) == 0;
      end
      if (reset) begin
        m_active[i] = 1'b0; m_t[i] = 0;
        e_pwm[i] = 1'b0; e_sd[i] = 1'b0; e_beep[i] = 1'b0; e_idx[i] = 0;
      end else begin
        if (!alarm) begin
          m_active[i] = 1'b0; m_t[i] = 0;
        end else if (!m_active[i]) begin
          m_active[i] = 1'b1; m_t[i] = 0;
        end else begin
          m_t[i]++;
        end
        nx_inb = 1'b0; idx = 0;
        if (m_active[i]) seg(m_t[i], m_n[i], nx_inb, off, idx);
        e_pwm[i]  = pre_inb && nx_inb && pre_th && (m_pwm < int'(volume));
        e_sd[i]   = m_active[i];
        e_beep[i] = nx_inb;
        e_idx[i]  = m_active[i] ? idx : 0;
      end
    end
    m_pwm = reset ? 0 : (m_pwm + 1) % 256;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // one clock: advance the model, let the DUT take the edge, compare all outputs
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("n3_pwm",  {31'd0, pwm3}, {31'd0, e_pwm[0]});
    chk("n3_sd",   {31'd0, sd3},  {31'd0, e_sd[0]});
    chk("n3_beep", {31'd0, bp3},  {31'd0, e_beep[0]});
    chk("n3_idx",  {24'd0, idx3}, e_idx[0]);
    chk("n1_pwm",  {31'd0, pwm1}, {31'd0, e_pwm[1]});
    chk("n1_sd",   {31'd0, sd1},  {31'd0, e_sd[1]});
    chk("n1_beep", {31'd0, bp1},  {31'd0, e_beep[1]});
    chk("n1_idx",  {24'd0, idx1}, e_idx[1]);
  endtask

  int cnt3, cnt1, cntp, cnts;

  initial begin
    reset = 1'b1; alarm = 1'b1; volume = 8'd255;
    m_active = '{1'b0, 1'b0}; m_t = '{0, 0}; m_pwm = 0;

    // reset dominates a high alarm
    repeat (3) cyc();
    chk("rst_sd", {31'd0, sd3}, 32'd0);
    chk("rst_beep", {31'd0, bp3}, 32'd0);
    chk("rst_pwm", {31'd0, pwm3}, 32'd0);

    // release: enabled and beeping on the first edge; 80-cycle cadence
    reset = 1'b0;
    cnt3 = 0; cnt1 = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (k == 0) begin
        chk("first_sd", {31'd0, sd3}, 32'd1);
        chk("first_beep", {31'd0, bp3}, 32'd1);
      end
      if (k == 8)  chk("idx_gap0", {24'd0, idx3}, 32'd1);
      if (k == 24) chk("idx_burst2", {24'd0, idx3}, 32'd2);
      if (k == 35) chk("idx_pause", {24'd0, idx3}, 32'd0);
      if (k == 42) chk("regroup_beep", {31'd0, bp3}, 32'd1);
      cnt3 += int'(bp3);
      cnt1 += int'(bp1);
    end
    chk("beep_cnt_n3", cnt3, 32'd48);
    chk("beep_cnt_n1", cnt1, 32'd40);

    // silent volume keeps the pin low while the amplifier stays enabled
    volume = 8'd0; cntp = 0; cnts = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      cntp += int'(pwm3) + int'(pwm1);
      cnts += int'(sd3);
    end
    chk("vol0_pwm", cntp, 32'd0);
    chk("vol0_sd", cnts, 32'd60);

    volume = 8'd128;
    repeat (300) cyc();

    // drop alarm on the third cycle of the second gap, then re-assert
    volume = 8'd255;
    reset = 1'b1; cyc();
    reset = 1'b0; cyc();
    repeat (22) cyc();
    alarm = 1'b0; cyc();
    chk("drop_sd", {31'd0, sd3}, 32'd0);
    chk("drop_idx", {24'd0, idx3}, 32'd0);
    chk("drop_beep", {31'd0, bp3}, 32'd0);
    repeat (4) cyc();
    alarm = 1'b1; cnt3 = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      cnt3 += int'(bp3 && idx3 == 8'd0);
    end
    chk("rearm_len", cnt3, 32'd8);
    cyc();
    chk("rearm_end", {31'd0, bp3}, 32'd0);

    // alarm drop and reset together mid-burst
    repeat (3) cyc();
    alarm = 1'b0; reset = 1'b1; cyc();
    chk("both_pwm", {31'd0, pwm3}, 32'd0);
    chk("both_sd", {31'd0, sd3}, 32'd0);
    reset = 1'b0;
    repeat (3) cyc();

    // random alarm, reset and volume activity
    alarm = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(99) < 3) alarm = ~alarm;
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(99) < 5) volume = 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
